// File: rtl/idec_pkg.sv
// Shared types and constants for the sequenced instruction decoder.
// The optional illegal-opcode trap is selected by IDEC_ILLEGAL_TRAP_EN in idecode_fsm.
package idec_pkg;

    localparam int unsigned IR_W      = 16;
    localparam int unsigned OPC_LSB   = 13;
    localparam int unsigned OPC_W     = 3;
    localparam int unsigned ALUOP_LSB = 11;
    localparam int unsigned ALUOP_W   = 2;
    localparam int unsigned RN_LSB    = 8;
    localparam int unsigned RD_LSB    = 5;
    localparam int unsigned RM_LSB    = 0;
    localparam int unsigned REG_W     = 3;
    localparam int unsigned SHIFT_LSB = 3;
    localparam int unsigned SHIFT_W   = 2;
    localparam int unsigned IMM5_W    = 5;
    localparam int unsigned IMM8_W    = 8;

    localparam logic [OPC_W-1:0] OP_MOV = 3'b110;
    localparam logic [OPC_W-1:0] OP_ALU = 3'b101;

    localparam logic [ALUOP_W-1:0] MOV_REG = 2'b00;
    localparam logic [ALUOP_W-1:0] MOV_IMM = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_CMP = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_MVN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG,
        S_HALT
    } state_t;

    // Per-cycle datapath control bundle
    typedef struct packed {
        logic [REG_W-1:0]   r_addr;
        logic [REG_W-1:0]   w_addr;
        logic [SHIFT_W-1:0] shift_op;
        logic               load_a;
        logic               load_b;
        logic               load_c;
        logic               load_s;
        logic               asel;
        logic               vsel;
        logic               rf_write;
        logic               done;
    } ctrl_t;

    function automatic logic is_legal(input logic [OPC_W-1:0] opc, input logic [ALUOP_W-1:0] op);
        return (opc == OP_ALU) || ((opc == OP_MOV) && ((op == MOV_IMM) || (op == MOV_REG)));
    endfunction

    function automatic logic is_cmp(input logic [OPC_W-1:0] opc, input logic [ALUOP_W-1:0] op);
        return (opc == OP_ALU) && (op == ALU_CMP);
    endfunction

endpackage

// File: rtl/idec_fields.sv
// Combinational field extraction and immediate sign extension from the latched IR.
module idec_fields
    import idec_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic [IR_W-1:0]    ir,
    output logic [OPC_W-1:0]   opcode,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [WORD_W-1:0]  sximm5,
    output logic [WORD_W-1:0]  sximm8
);

    if (WORD_W < 16) begin : g_width_check
        $error("idec_fields: WORD_W must be at least 16");
    end

    assign opcode = ir[OPC_LSB +: OPC_W];
    assign alu_op = ir[ALUOP_LSB +: ALUOP_W];
    assign sximm5 = {{(WORD_W - IMM5_W){ir[IMM5_W-1]}}, ir[IMM5_W-1:0]};
    assign sximm8 = {{(WORD_W - IMM8_W){ir[IMM8_W-1]}}, ir[IMM8_W-1:0]};

endmodule

// File: rtl/idecode_fsm.sv
// Sequenced instruction decoder: latches one instruction and steps the datapath through it.
// Define IDEC_ILLEGAL_TRAP_EN to trap undefined instructions in HALT; otherwise they run as a NOP.
module idecode_fsm
    import idec_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [15:0]       in_ir,
    output logic              in_ready,
    output logic [2:0]        opcode,
    output logic [1:0]        ALU_op,
    output logic [1:0]        shift_op,
    output logic [WORD_W-1:0] sximm5,
    output logic [WORD_W-1:0] sximm8,
    output logic [2:0]        r_addr,
    output logic [2:0]        w_addr,
    output logic              load_a,
    output logic              load_b,
    output logic              load_c,
    output logic              load_s,
    output logic              asel,
    output logic              vsel,
    output logic              rf_write,
    output logic              done,
    output logic              illegal
);

    state_t          state;
    state_t          state_nxt;
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_nxt;
    ctrl_t           ctrl;
    ctrl_t           ctrl_nxt;

    idec_fields #(.WORD_W(WORD_W)) u_fields (
        .ir     (ir),
        .opcode (opcode),
        .alu_op (ALU_op),
        .sximm5 (sximm5),
        .sximm8 (sximm8)
    );

    // First state after accepting an instruction
    function automatic state_t entry_state(input logic [OPC_W-1:0] opc, input logic [ALUOP_W-1:0] op);
        state_t s;
        if (!is_legal(opc, op)) begin
`ifdef IDEC_ILLEGAL_TRAP_EN
            s = S_HALT;
`else
            s = S_EXEC;
`endif
        end else if (opc == OP_MOV) begin
            s = (op == MOV_IMM) ? S_WRITE_IMM : S_GET_B;
        end else begin
            s = (op == ALU_MVN) ? S_GET_B : S_GET_A;
        end
        return s;
    endfunction

    // Strobes for a given state and instruction; an undefined instruction in EXEC only reports done
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [IR_W-1:0] i);
        ctrl_t               c;
        logic [OPC_W-1:0]    opc;
        logic [ALUOP_W-1:0]  op;
        opc = i[OPC_LSB +: OPC_W];
        op  = i[ALUOP_LSB +: ALUOP_W];
        c   = '0;
        case (s)
            S_WRITE_IMM: begin
                c.w_addr   = i[RN_LSB +: REG_W];
                c.vsel     = 1'b1;
                c.rf_write = 1'b1;
                c.done     = 1'b1;
            end
            S_GET_A: begin
                c.r_addr = i[RN_LSB +: REG_W];
                c.load_a = 1'b1;
            end
            S_GET_B: begin
                c.r_addr   = i[RM_LSB +: REG_W];
                c.load_b   = 1'b1;
                c.shift_op = i[SHIFT_LSB +: SHIFT_W];
            end
            S_EXEC: begin
                if (!is_legal(opc, op)) begin
                    c.done = 1'b1;
                end else if (is_cmp(opc, op)) begin
                    c.load_s = 1'b1;
                    c.done   = 1'b1;
                end else begin
                    c.load_c = 1'b1;
                    c.asel   = (opc == OP_MOV);
                end
            end
            S_WRITE_REG: begin
                c.w_addr   = i[RD_LSB +: REG_W];
                c.rf_write = 1'b1;
                c.done     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    ir_nxt    = in_ir;
                    state_nxt = entry_state(in_ir[OPC_LSB +: OPC_W], in_ir[ALUOP_LSB +: ALUOP_W]);
                end
            end
            S_WRITE_IMM: state_nxt = S_IDLE;
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_EXEC;
            S_EXEC: begin
                if (!is_legal(ir[OPC_LSB +: OPC_W], ir[ALUOP_LSB +: ALUOP_W]) ||
                    is_cmp(ir[OPC_LSB +: OPC_W], ir[ALUOP_LSB +: ALUOP_W]))
                    state_nxt = S_IDLE;
                else
                    state_nxt = S_WRITE_REG;
            end
            S_WRITE_REG: state_nxt = S_IDLE;
`ifdef IDEC_ILLEGAL_TRAP_EN
            S_HALT:      state_nxt = S_HALT;
`endif
            default:     state_nxt = S_IDLE;
        endcase
        ctrl_nxt = decode_ctrl(state_nxt, ir_nxt);
    end

    // Outputs are registered from the next-state decode so they align with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ir       <= '0;
            ctrl     <= '0;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            ir       <= ir_nxt;
            ctrl     <= ctrl_nxt;
            in_ready <= (state_nxt == S_IDLE);
        end
    end

`ifdef IDEC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal <= 1'b0;
        else if (state_nxt == S_HALT)
            illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    assign r_addr   = ctrl.r_addr;
    assign w_addr   = ctrl.w_addr;
    assign shift_op = ctrl.shift_op;
    assign load_a   = ctrl.load_a;
    assign load_b   = ctrl.load_b;
    assign load_c   = ctrl.load_c;
    assign load_s   = ctrl.load_s;
    assign asel     = ctrl.asel;
    assign vsel     = ctrl.vsel;
    assign rf_write = ctrl.rf_write;
    assign done     = ctrl.done;

endmodule

// File: tb/tb_idecode_fsm.sv
// Self-checking bench for idecode_fsm: per-cycle expectation schedule model plus directed pins.
module tb_idecode_fsm;

    localparam int unsigned WORD_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [15:0]       in_ir = 16'h0000;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [1:0]        ALU_op;
    logic [1:0]        shift_op;
    logic [WORD_W-1:0] sximm5;
    logic [WORD_W-1:0] sximm8;
    logic [2:0]        r_addr;
    logic [2:0]        w_addr;
    logic              load_a, load_b, load_c, load_s, asel, vsel, rf_write, done, illegal;

    always #5 clk = ~clk;

    idecode_fsm #(.WORD_W(WORD_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(in_ir), .in_ready(in_ready),
        .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op), .sximm5(sximm5), .sximm8(sximm8),
        .r_addr(r_addr), .w_addr(w_addr), .load_a(load_a), .load_b(load_b), .load_c(load_c),
        .load_s(load_s), .asel(asel), .vsel(vsel), .rf_write(rf_write), .done(done), .illegal(illegal)
    );

    typedef struct packed {
        logic [2:0] r_addr;
        logic [2:0] w_addr;
        logic [1:0] shift_op;
        logic       load_a, load_b, load_c, load_s, asel, vsel, rf_write, done, in_ready, illegal;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    bit          started = 0;
    exp_t        cur;
    exp_t        sched[$];
    logic [15:0] mir;
    bit          halted;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic exp_t step(input logic [2:0] ra, input logic [2:0] wa, input logic [1:0] sh,
                                  input logic la, input logic lb, input logic lc, input logic ls,
                                  input logic as, input logic vs, input logic wr, input logic dn);
        exp_t e;
        e = '{ra, wa, sh, la, lb, lc, ls, as, vs, wr, dn, 1'b0, 1'b0};
        return e;
    endfunction

    function automatic exp_t idle_rec();
        exp_t e;
        e = '0;
        e.in_ready = 1'b1;
        return e;
    endfunction

    // Expected cycle-by-cycle schedule for one accepted instruction
    task automatic plan(input logic [15:0] i);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        exp_t ga, gb, wr;
        opc = i[15:13]; op = i[12:11]; rn = i[10:8]; rd = i[7:5]; rm = i[2:0]; sh = i[4:3];
        ga = step(rn, 3'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        gb = step(rm, 3'd0, sh, 0, 1, 0, 0, 0, 0, 0, 0);
        wr = step(3'd0, rd, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1);
        if (opc == 3'b110 && op == 2'b10) begin
            sched.push_back(step(3'd0, rn, 2'd0, 0, 0, 0, 0, 0, 1, 1, 1));
        end else if (opc == 3'b110 && op == 2'b00) begin
            sched.push_back(gb);
            sched.push_back(step(3'd0, 3'd0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 0));
            sched.push_back(wr);
        end else if (opc == 3'b101) begin
            if (op != 2'b11) sched.push_back(ga);
            sched.push_back(gb);
            if (op == 2'b01) begin
                sched.push_back(step(3'd0, 3'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 1));
            end else begin
                sched.push_back(step(3'd0, 3'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0));
                sched.push_back(wr);
            end
        end else begin
`ifdef IDEC_ILLEGAL_TRAP_EN
            halted = 1;
`else
            sched.push_back(step(3'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
        end
    endtask

    // Reference model: advances one expectation per clock
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sched.delete();
            halted = 0;
            mir    = 16'h0000;
            cur    = idle_rec();
        end else begin
            if (cur.in_ready && in_valid) begin
                mir = in_ir;
                plan(in_ir);
            end
            if (halted) begin
                cur = '0;
                cur.illegal = 1'b1;
            end else if (sched.size() > 0) begin
                cur = sched.pop_front();
            end else begin
                cur = idle_rec();
            end
        end
    end

    // Compare process
    always @(negedge clk) begin : compare
        int v5, v8;
        if (started) begin
            check("ctrl", 64'({r_addr, w_addr, shift_op, load_a, load_b, load_c, load_s, asel, vsel,
                               rf_write, done, in_ready, illegal}), 64'(cur));
            v5 = int'(mir[4:0]);
            if (v5 > 15) v5 = v5 - 32;
            v8 = int'(mir[7:0]);
            if (v8 > 127) v8 = v8 - 256;
            check("fields", 64'({opcode, ALU_op, sximm5, sximm8}),
                  64'({mir[15:13], mir[12:11], 16'(v5), 16'(v8)}));
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic send(input logic [15:0] i);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_ir    = i;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_ir();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 9))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:11] = 5'b10100;
            3: r[15:11] = 5'b10101;
            4: r[15:11] = 5'b10110;
            5: r[15:11] = 5'b10111;
            6: r[15:11] = 5'b11001;
            7: r[15:11] = 5'b11011;
            8: r[15:13] = 3'b111;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int hcnt;
        #1 reset = 1'b1;
        #1 started = 1;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // MOV R0,#-3
        send(16'hD0FD);
        check("movi_w_addr", 64'(w_addr), 64'd0);
        check("movi_vsel_wr_done", 64'({vsel, rf_write, done}), 64'b111);
        check("movi_sximm8", 64'(sximm8), 64'hFFFD);
        @(negedge clk);
        check("movi_ready_after", 64'({in_ready, done}), 64'b10);

        // ADD R2,R1,R0 LSL #1
        send(16'hA148);
        check("add_c1", 64'({r_addr, load_a, load_b}), 64'({3'd1, 2'b10}));
        @(negedge clk);
        check("add_c2", 64'({r_addr, load_b, shift_op}), 64'({3'd0, 1'b1, 2'b01}));
        @(negedge clk);
        check("add_c3", 64'({load_c, rf_write, done}), 64'b100);
        @(negedge clk);
        check("add_c4", 64'({w_addr, rf_write, done}), 64'({3'd2, 2'b11}));

        // CMP R1,R0
        send(16'hA900);
        check("cmp_c1", 64'({rf_write, load_s}), 64'b00);
        @(negedge clk);
        check("cmp_c2", 64'({rf_write, load_s}), 64'b00);
        @(negedge clk);
        check("cmp_c3", 64'({load_s, done, rf_write, load_c}), 64'b1100);

        // MVN R3,R4 with in_valid held high through execution
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_ir    = 16'hB864;
        @(negedge clk);
        in_ir = 16'hD1FF;
        check("mvn_c1", 64'({r_addr, in_ready}), 64'({3'd4, 1'b0}));
        @(negedge clk);
        check("mvn_c2_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("mvn_c3", 64'({w_addr, rf_write, done, in_ready}), 64'({3'd3, 3'b110}));
        @(negedge clk);
        check("mvn_c4", 64'({in_ready, done}), 64'b10);
        @(negedge clk);
        in_valid = 1'b0;
        check("held_movi", 64'({w_addr, done, sximm8}), 64'({3'd1, 1'b1, 16'hFFFF}));

        // Reset during GET_B of ADD
        send(16'hA148);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("rst_async", 64'({load_b, r_addr, in_ready, done}), 64'({1'b0, 3'd0, 2'b10}));
        @(negedge clk);
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_write", 64'({rf_write, in_ready, illegal}), 64'b010);
        end

        // Randomized traffic, including in_valid asserted while busy
        hcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hcnt = halted ? hcnt + 1 : 0;
            if (hcnt > 3) begin
                in_valid = 1'b0;
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
                hcnt = 0;
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ir    = rand_ir();
            end
        end

        // Undefined instruction
        in_valid = 1'b0;
        pulse_reset();
        send(16'hE000);
`ifdef IDEC_ILLEGAL_TRAP_EN
        check("ill_c1", 64'({illegal, in_ready, done, rf_write}), 64'b1000);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("ill_halt", 64'({illegal, in_ready}), 64'b10);
        end
        pulse_reset();
`else
        check("nop_c1", 64'({done, load_a, load_b, load_c, load_s, rf_write, illegal}), 64'b1000000);
        @(negedge clk);
        check("nop_after", 64'({in_ready, done, illegal}), 64'b100);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
